// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types and constants for the memory stage: FSM state
//               encoding, funct3 size/sign codes and small helpers for
//               alignment checking and byte-enable generation.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  // Memory-stage sequencer states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  // funct3 access codes (bit 2 selects zero-extension for loads).
  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_d  = 3'b011;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;
  localparam logic [2:0] c_f3_wu = 3'b110;

  // Access size, taken from funct3[1:0].
  localparam logic [1:0] c_sz_b = 2'd0;
  localparam logic [1:0] c_sz_h = 2'd1;
  localparam logic [1:0] c_sz_w = 2'd2;
  localparam logic [1:0] c_sz_d = 2'd3;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic res;
    res = 1'b0;
    case (size)
      c_sz_b:  res = 1'b0;
      c_sz_h:  res = off[0];
      c_sz_w:  res = |off[1:0];
      c_sz_d:  res = |off;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Byte lanes touched by an aligned access of the given size.
  function automatic logic [7:0] byte_enable(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] be;
    be = 8'h00;
    case (size)
      c_sz_b:  be = 8'h01 << off;
      c_sz_h:  be = 8'h03 << off;
      c_sz_w:  be = 8'h0F << off;
      c_sz_d:  be = 8'hFF;
      default: be = 8'h00;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load-data alignment. Shifts the addressed lane
//               down to bit 0 and sign- or zero-extends it according to
//               funct3.
// Ports       : rdata_i  [63:0] raw 64-bit word from data memory
//               offset_i [2:0]  byte offset of the access within the word
//               funct3_i [2:0]  load size/sign code
//               data_o   [63:0] aligned, extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mem_stage_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  logic [63:0] w_shifted;

  always_comb begin
    w_shifted = rdata_i >> {offset_i, 3'b000};
    data_o    = w_shifted;
    case (funct3_i)
      c_f3_b:  data_o = {{56{w_shifted[7]}},  w_shifted[7:0]};
      c_f3_h:  data_o = {{48{w_shifted[15]}}, w_shifted[15:0]};
      c_f3_w:  data_o = {{32{w_shifted[31]}}, w_shifted[31:0]};
      c_f3_d:  data_o = w_shifted;
      c_f3_bu: data_o = {56'd0, w_shifted[7:0]};
      c_f3_hu: data_o = {48'd0, w_shifted[15:0]};
      c_f3_wu: data_o = {32'd0, w_shifted[31:0]};
      default: data_o = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage. Passes non-memory results straight to
//               writeback, issues one data-memory request per load/store with
//               a req/gnt handshake followed (for loads) by an rvalid
//               response, and reports misaligned/illegal accesses as faults.
// Ports       : clk, rst_n                 clock, async active-low reset
//               valid_i, alu_result_i,
//               rs2_data_i, rd_addr_i,
//               reg_write_i, mem_read_i,
//               mem_write_i, funct3_i      incoming instruction
//               dmem_req_o/we_o/addr_o/
//               wdata_o/be_o               data-memory request
//               dmem_gnt_i, dmem_rvalid_i,
//               dmem_rdata_i               data-memory grant / response
//               stall_o                    stage busy, input not accepted
//               wb_valid_o, wb_data_o,
//               wb_rd_addr_o,
//               wb_reg_write_o             registered writeback
//               fault_o                    access fault, aligned with wb_valid_o
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [63:0] alu_result_i,
  input  logic [63:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  output logic [7:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [63:0] wb_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_reg_write_o,
  output logic        fault_o
);

  mem_state_e  r_state;

  // Captured request; write data and byte enables are pre-shifted at capture
  // so the request outputs come straight from registers.
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_be;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_store;

  logic        r_wb_valid;
  logic [63:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_wb_reg_write;
  logic        r_fault;

  logic        w_is_mem;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_in_req;
  logic [63:0] w_load_data;

  assign w_is_mem     = mem_read_i | mem_write_i;
  assign w_illegal    = (mem_read_i & mem_write_i)
                      | (mem_read_i & (funct3_i == 3'b111))
                      | (mem_write_i & funct3_i[2]);
  assign w_misaligned = misaligned(funct3_i[1:0], alu_result_i[2:0]);

  load_align u_load_align (
    .rdata_i  (dmem_rdata_i),
    .offset_i (r_addr[2:0]),
    .funct3_i (r_funct3),
    .data_o   (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_addr         <= 64'd0;
      r_wdata        <= 64'd0;
      r_be           <= 8'd0;
      r_funct3       <= 3'd0;
      r_rd           <= 5'd0;
      r_reg_write    <= 1'b0;
      r_store        <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_data      <= 64'd0;
      r_wb_rd        <= 5'd0;
      r_wb_reg_write <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      // Writeback strobe and fault are single-cycle pulses.
      r_wb_valid <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            if (!w_is_mem) begin
              r_wb_valid     <= 1'b1;
              r_wb_data      <= alu_result_i;
              r_wb_rd        <= rd_addr_i;
              r_wb_reg_write <= reg_write_i & (rd_addr_i != 5'd0);
            end else if (w_illegal | w_misaligned) begin
              // Faulting address is reported on the data bus; no request.
              r_wb_valid     <= 1'b1;
              r_fault        <= 1'b1;
              r_wb_data      <= alu_result_i;
              r_wb_rd        <= rd_addr_i;
              r_wb_reg_write <= 1'b0;
            end else begin
              r_addr      <= alu_result_i;
              r_wdata     <= rs2_data_i << {alu_result_i[2:0], 3'b000};
              r_be        <= byte_enable(funct3_i[1:0], alu_result_i[2:0]);
              r_funct3    <= funct3_i;
              r_rd        <= rd_addr_i;
              r_reg_write <= reg_write_i;
              r_store     <= mem_write_i;
              r_state     <= REQ;
            end
          end
        end
        REQ: begin
          // Any rvalid seen here is not ours; only the grant matters.
          if (dmem_gnt_i) begin
            if (r_store) begin
              r_wb_valid     <= 1'b1;
              r_wb_rd        <= r_rd;
              r_wb_reg_write <= 1'b0;
              r_state        <= IDLE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            r_wb_valid     <= 1'b1;
            r_wb_data      <= w_load_data;
            r_wb_rd        <= r_rd;
            r_wb_reg_write <= r_reg_write & (r_rd != 5'd0);
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Request fields are qualified by the REQ state so they read zero whenever
  // no request is outstanding, including immediately on reset.
  assign w_in_req     = (r_state == REQ);
  assign dmem_req_o   = w_in_req;
  assign dmem_we_o    = w_in_req & r_store;
  assign dmem_addr_o  = w_in_req ? r_addr : 64'd0;
  assign dmem_wdata_o = (w_in_req & r_store) ? r_wdata : 64'd0;
  assign dmem_be_o    = w_in_req ? r_be : 8'd0;

  assign stall_o        = (r_state != IDLE);
  assign wb_valid_o     = r_wb_valid;
  assign wb_data_o      = r_wb_data;
  assign wb_rd_addr_o   = r_wb_rd;
  assign wb_reg_write_o = r_wb_reg_write;
  assign fault_o        = r_fault;

endmodule
`default_nettype wire
